uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Parametrised UART receive core: oversampling front end, configurable framing and a per-entry error-tagged receive FIFO with RTS flow control. It replaces the fixed-format receiver path behind the `UART_IFace` signals `Rx`, `Data_Out`, `Data_Rdy`, `Rx_Error`, `Read_Done`, `FIFO_*` and `RTS`. It adds several things the previous receiver lacked:
- parity mode selectable at run time;
- 16x oversampling with majority vote;
- false-start rejection;
- break detection;
- error flags stored per FIFO entry.

## Interface
Parameters:
- SYSCLK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in baud. OVS_DIV = SYSCLK_RATE/(16*BAUD_RATE), floor, must be ≥2.
- DATA_BITS, 8, data bits per frame, 5..9.
- STOP_BITS, 2, stop bits per frame, 1 or 2.
- FIFO_DEPTH, 8, receive FIFO entries, power of 2, ≥2.
- RTS_THRESH, FIFO_DEPTH-2, fill level at which RTS deasserts.

Ports:
- SysClk  in  1  single system clock; all logic on its rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Rx  in  1  serial line, asynchronous to SysClk, idle high.
- Rx_Enable  in  1  1 = accept new frames.
- Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 none.
- Read_Done  in  1  pop strobe, one SysClk cycle wide.
- Data_Out  out  DATA_BITS  data of the FIFO head entry.
- Rx_Error  out  3  FIFO head error flags {Break, Frame, Parity}.
- Data_Rdy  out  1  head entry valid; equals !FIFO_Empty.
- FIFO_Empty  out  1  FIFO holds no entries.
- FIFO_Full  out  1  count == FIFO_DEPTH.
- FIFO_Overflow  out  1  sticky; a received frame was dropped.
- RTS  out  1  1 = sender may transmit.
- Rx_Busy  out  1  FSM is not IDLE.

## Operation
- Rx passes through a 2-flop synchronizer; both flops reset to 1.
- Tick generator: counter 0..OVS_DIV-1 produces a one-cycle tick on wrap. It restarts at 0 on start-edge detection.
- Each bit lasts 16 ticks. The bit value is the majority of samples at ticks 7, 8 and 9; it is registered at tick 9 ("bit sample").
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when Rx_Enable=1 and the synced Rx goes 1→0, enter START. Parity_Mode is latched here and held for the whole frame.
- START: at the bit sample, vote=1 means a false start: return to IDLE, no entry. Vote=0 goes to DATA.
- DATA: shift DATA_BITS bits, LSB first, with a running XOR. Go to PARITY if the latched mode is even or odd, else to STOP.
- PARITY: Parity flag = (received bit != expected). Even: expected = XOR of data bits. Odd: expected = inverted XOR.
- STOP: sample STOP_BITS bits. Any 0 sets Frame. Break = all data bits 0, parity bit (if present) 0, and first stop bit 0; Break also sets Frame.
- Commit: one cycle after the last stop bit sample, push {Break, Frame, Parity, data}.
- After commit: if Frame=1 go to WAIT_IDLE, which stays until the synced Rx=1, then goes to IDLE. Otherwise go directly to IDLE.
- Rx_Enable deasserted mid-frame: the current frame completes and commits; no new start is accepted.
- FIFO is first-word-fall-through. Data_Out and Rx_Error present the head entry directly from registers. They hold their last value when empty.
- Pop: Read_Done=1 while not empty removes the head. Read_Done while empty is ignored.
- Push while full without a pop: the entry is dropped and FIFO_Overflow sets. FIFO_Overflow clears on the next accepted pop.
- Push and pop in the same cycle: both happen and the count is unchanged. When full, this is not an overflow.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- RTS is registered: RTS = (count < RTS_THRESH).

## Timing
- Reset values:
  - FSM IDLE, FIFO empty.
  - Data_Out 0, Rx_Error 0.
  - Data_Rdy 0, FIFO_Empty 1, FIFO_Full 0, FIFO_Overflow 0.
  - RTS 0, rising to 1 on the first clock edge after Rst_n deasserts.
  - Rx_Busy 0.
- Reset asserted mid-frame: the frame is abandoned, all state returns to reset values, and the FIFO contents are lost.
- Latency:
  - Line edge to START: 3 SysClk (2 synchronizer flops plus edge register).
  - Last stop bit sample to FIFO_Empty falling: 2 cycles (commit register, then write).
- Read_Done in cycle N: the next entry appears on Data_Out/Rx_Error, and FIFO_Empty/FIFO_Full/RTS update, at edge N+1.
- One frame spans (1 + DATA_BITS + parity + STOP_BITS)*16*OVS_DIV cycles.
- The receiver tolerates sender baud error up to ±3%.

## Test plan
Default bench configuration: SYSCLK_RATE=1600000, BAUD_RATE=10000 (OVS_DIV=10, 160 cycles/bit), DATA_BITS=8, STOP_BITS=2, FIFO_DEPTH=8, RTS_THRESH=6.

1. Even parity, send 0xA5 with parity 0 → one entry: Data_Out=0xA5, Rx_Error=000, Data_Rdy=1. Read_Done → FIFO_Empty=1 at the next edge.
2. Odd parity, send 0x01 with parity 1 → Rx_Error=001. Mode 00, send 0x3C with no parity bit → Rx_Error=000.
3. Stop bits driven 0 on 0x55 → Rx_Error=010 and FSM holds WAIT_IDLE until Rx=1. All-zero frame, line low for 12 bits → Rx_Error=110.
4. 60-cycle low glitch on an idle line → no entry, Rx_Busy returns to 0. Rst_n pulsed mid-frame → all outputs at reset values, no entry.
5. Flow control and overflow:
   - Send 9 frames 0x00..0x08 with no reads → RTS=0 after the 6th, FIFO_Full=1 after the 8th, 9th dropped with FIFO_Overflow=1.
   - Reads return 0x00..0x07 in order; FIFO_Overflow clears on the first pop.
6. FIFO full, Read_Done coincides with a commit → count stays 8, FIFO_Overflow=0, new data at the tail.

Source files
------------

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core: 16x oversampling UART receiver with run-time parity and an error-tagged FWFT FIFO with RTS
// Ports: SysClk clock; Rst_n async active-low reset; Rx serial line (idle high); Rx_Enable accepts new frames;
// Parity_Mode 00/11 none, 01 even, 10 odd; Read_Done pops the head; Data_Out/Rx_Error head data and
// {Break, Frame, Parity}; Data_Rdy/FIFO_Empty/FIFO_Full/FIFO_Overflow FIFO status; RTS sender may transmit;
// Rx_Busy receiver is inside a frame.
module uart_rx_core #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int RTS_THRESH = FIFO_DEPTH - 2
) (
  input  logic                 SysClk,
  input  logic                 Rst_n,
  input  logic                 Rx,
  input  logic                 Rx_Enable,
  input  logic [1:0]           Parity_Mode,
  input  logic                 Read_Done,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic [2:0]           Rx_Error,
  output logic                 Data_Rdy,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS,
  output logic                 Rx_Busy
);
  localparam int OVS_DIV = SYSCLK_RATE / (16 * BAUD_RATE);
  localparam int DW = $clog2(OVS_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 3;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state_q;
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DW-1:0] div_q;
  logic [3:0] tick_q;
  logic s7_q, s8_q;
  logic [1:0] mode_q;
  logic [BW-1:0] bit_q;
  logic stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic par_q, zero_q, brk_q, frm_q, perr_q, last_q, commit_q;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [EW-1:0] head_q, head_d;
  logic ovf_q, rts_q;
  logic start_edge, tick, sample, vote, last_stop, pop, full, accept;
  logic [EW-1:0] entry;
  assign start_edge = state_q == IDLE && Rx_Enable && rx_prev_q && !rx_sync_q;
  assign tick = div_q == DW'(OVS_DIV - 1);
  assign sample = tick && tick_q == 4'd9;
  assign vote = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);
  assign last_stop = state_q == STOP && sample && stop_q == 1'(STOP_BITS - 1);
  always_ff @(posedge SysClk or negedge Rst_n)
    if (!Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q <= '0;
      tick_q <= '0;
      s7_q <= 1'b0;
      s8_q <= 1'b0;
      state_q <= IDLE;
      mode_q <= '0;
      bit_q <= '0;
      stop_q <= 1'b0;
      shift_q <= '0;
      par_q <= 1'b0;
      zero_q <= 1'b0;
      brk_q <= 1'b0;
      frm_q <= 1'b0;
      perr_q <= 1'b0;
      last_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      div_q <= (start_edge || tick) ? '0 : div_q + 1'b1;
      tick_q <= start_edge ? '0 : tick ? tick_q + 1'b1 : tick_q;
      if (tick && tick_q == 4'd7) s7_q <= rx_sync_q;
      if (tick && tick_q == 4'd8) s8_q <= rx_sync_q;
      last_q <= last_stop;
      commit_q <= last_q;
      case (state_q)
        IDLE: if (start_edge) begin
          state_q <= START;
          mode_q <= Parity_Mode;
          bit_q <= '0;
          stop_q <= 1'b0;
          par_q <= 1'b0;
          zero_q <= 1'b1;
          brk_q <= 1'b0;
          frm_q <= 1'b0;
          perr_q <= 1'b0;
        end
        START: if (sample) state_q <= vote ? IDLE : DATA;
        DATA: if (sample) begin
          shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          par_q <= par_q ^ vote;
          zero_q <= zero_q & !vote;
          bit_q <= bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) state_q <= ^mode_q ? PARITY : STOP;
        end
        // odd parity expects the inverted data XOR; mode_q[1] is set only for odd
        PARITY: if (sample) begin
          perr_q <= vote != (par_q ^ mode_q[1]);
          zero_q <= zero_q & !vote;
          state_q <= STOP;
        end
        // flags settle at the last stop sample; the FSM leaves STOP on the following commit cycle
        STOP: if (last_q) state_q <= frm_q ? WAIT_IDLE : IDLE;
        else if (sample) begin
          frm_q <= frm_q | !vote;
          stop_q <= stop_q + 1'b1;
          if (!stop_q) brk_q <= zero_q & !vote;
        end
        WAIT_IDLE: if (rx_sync_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign pop = Read_Done && cnt_q != '0;
  assign accept = commit_q && (!full || pop);
  assign entry = {brk_q, frm_q, perr_q, shift_q};
  // head register shows the entry that will be at the front after this cycle, holding when empty
  always_comb begin
    cnt_d = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
    head_d = cnt_d == '0 ? head_q
           : (cnt_q == '0 || (pop && cnt_q == (AW+1)'(1))) ? entry
           : pop ? mem_q[rd_q + 1'b1] : head_q;
  end
  always_ff @(posedge SysClk)
    if (accept) mem_q[wr_q] <= entry;
  always_ff @(posedge SysClk or negedge Rst_n)
    if (!Rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
      ovf_q <= 1'b0;
      rts_q <= 1'b0;
    end else begin
      wr_q <= wr_q + AW'(accept);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
      head_q <= head_d;
      ovf_q <= pop ? 1'b0 : ovf_q | (commit_q && !accept);
      rts_q <= cnt_d < (AW+1)'(RTS_THRESH);
    end
  assign Data_Out = head_q[DATA_BITS-1:0];
  assign Rx_Error = head_q[EW-1:DATA_BITS];
  assign Data_Rdy = cnt_q != '0;
  assign FIFO_Empty = cnt_q == '0;
  assign FIFO_Full = full;
  assign FIFO_Overflow = ovf_q;
  assign RTS = rts_q;
  assign Rx_Busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// tb_uart_rx_core: randomized self-checking bench for uart_rx_core against a frame-level reference model
module tb_uart_rx_core;
  localparam int BIT = 160;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_en = 1'b1, rd = 1'b0;
  logic [1:0] pmode = 2'b00;
  logic [7:0] data_out;
  logic [2:0] rx_err;
  logic data_rdy, empty, full, ovf, rts, busy;
  logic [10:0] q[$];
  logic m_ovf = 1'b0;
  logic [10:0] shown = '0;
  int n_chk = 0, n_fail = 0, t_wait = 0;
  logic [7:0] r_d;
  logic [1:0] r_m;
  logic r_pb, r_s0, r_s1, r_e0, r_e1;
  always #5 clk = ~clk;
  uart_rx_core #(.SYSCLK_RATE(1600000), .BAUD_RATE(10000), .DATA_BITS(8), .STOP_BITS(2),
                 .FIFO_DEPTH(8), .RTS_THRESH(6)) dut (
    .SysClk(clk), .Rst_n(rst_n), .Rx(rx), .Rx_Enable(rx_en), .Parity_Mode(pmode), .Read_Done(rd),
    .Data_Out(data_out), .Rx_Error(rx_err), .Data_Rdy(data_rdy), .FIFO_Empty(empty), .FIFO_Full(full),
    .FIFO_Overflow(ovf), .RTS(rts), .Rx_Busy(busy));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, " rdy"}, 32'(data_rdy), 32'(q.size() != 0));
    check({tag, " full"}, 32'(full), 32'(q.size() == 8));
    check({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, " rts"}, 32'(rts), 32'(rst_n && q.size() < 6));
    check({tag, " data"}, 32'(data_out), 32'(shown[7:0]));
    check({tag, " err"}, 32'(rx_err), 32'(shown[10:8]));
  endtask
  function automatic logic [10:0] ref_entry(input logic [7:0] d, input logic [1:0] m, input logic pb,
                                            input logic s0, input logic s1);
    logic pe, perr, brk, frm;
    pe = (m == 2'b01) || (m == 2'b10);
    perr = pe && (pb != ((^d) ^ (m == 2'b10)));
    brk = (d == 8'h00) && (!pe || !pb) && !s0;
    frm = !s0 || !s1 || brk;
    return {brk, frm, perr, d};
  endfunction
  task automatic model_push(input logic [10:0] e);
    if (q.size() < 8) q.push_back(e);
    else m_ovf = 1'b1;
    if (q.size() != 0) shown = q[0];
  endtask
  task automatic model_pop();
    if (q.size() != 0) begin
      void'(q.pop_front());
      m_ovf = 1'b0;
    end
    if (q.size() != 0) shown = q[0];
  endtask
  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    shown = '0;
  endtask
  task automatic bit_out(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic [1:0] m, input logic pb, input logic s0,
                            input logic s1, input logic en0, input logic en1, input logic tail);
    rx_en = en0;
    pmode = m;
    bit_out(1'b0, BIT);
    rx_en = en0 & en1;
    pmode = 2'($urandom);
    for (int i = 0; i < 8; i++) bit_out(d[i], BIT);
    if (m == 2'b01 || m == 2'b10) bit_out(pb, BIT);
    bit_out(s0, BIT);
    bit_out(s1, BIT);
    rx = tail;
  endtask
  task automatic pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    model_pop();
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (5) @(negedge clk);
    check_state("reset");
    check("reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("post reset");
    send_frame(8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    model_push(ref_entry(8'hA5, 2'b01, 1'b0, 1'b1, 1'b1));
    check_state("t1");
    check("t1 const", 32'({rx_err, data_out}), 32'h0A5);
    pop();
    check_state("t1 pop");
    send_frame(8'h01, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    model_push(ref_entry(8'h01, 2'b10, 1'b1, 1'b1, 1'b1));
    check_state("t2 odd");
    check("t2 odd err", 32'(rx_err), 32'h1);
    pop();
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    model_push(ref_entry(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1));
    check_state("t2 none");
    check("t2 none err", 32'(rx_err), 32'h0);
    pop();
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    bit_out(1'b0, BIT);
    model_push(ref_entry(8'h55, 2'b00, 1'b0, 1'b0, 1'b0));
    check_state("t3 frame");
    check("t3 frame err", 32'(rx_err), 32'h2);
    check("t3 wait busy", 32'(busy), 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("t3 idle busy", 32'(busy), 0);
    pop();
    send_frame(8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    bit_out(1'b0, BIT);
    model_push(ref_entry(8'h00, 2'b01, 1'b0, 1'b0, 1'b0));
    check_state("t3 break");
    check("t3 break err", 32'(rx_err), 32'h6);
    check("t3 break busy", 32'(busy), 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("t3 break idle", 32'(busy), 0);
    pop();
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    model_push(ref_entry(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1));
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("t4 glitch busy", 32'(busy), 1);
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    check("t4 glitch idle", 32'(busy), 0);
    check_state("t4 glitch");
    bit_out(1'b0, BIT);
    bit_out(1'b1, BIT);
    bit_out(1'b0, BIT / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    check_state("t4 in reset");
    check("t4 reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("t4 release");
    repeat (2000) @(negedge clk);
    check_state("t4 after");
    check("t4 after busy", 32'(busy), 0);
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (40) @(negedge clk);
      model_push(ref_entry(8'(i), 2'b00, 1'b0, 1'b1, 1'b1));
      check_state($sformatf("t5 f%0d", i));
    end
    fork
      send_frame(8'h09, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      begin
        t_wait = 0;
        while (!busy && t_wait < 500) begin @(negedge clk); t_wait++; end
        while (busy && t_wait < 3000) begin @(negedge clk); t_wait++; end
        check("t6 busy fall", 32'(busy), 0);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        model_pop();
        model_push(ref_entry(8'h09, 2'b00, 1'b0, 1'b1, 1'b1));
        check_state("t6 coincide");
      end
    join
    repeat (40) @(negedge clk);
    check_state("t6 settled");
    for (int i = 0; i < 8; i++) begin
      pop();
      check_state($sformatf("t5 read%0d", i));
    end
    pop();
    check_state("empty pop");
    for (int i = 0; i < 10; i++) begin
      r_d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      r_m = 2'($urandom_range(0, 3));
      r_pb = ($urandom_range(0, 3) == 0) ^ (^r_d) ^ (r_m == 2'b10);
      r_s0 = $urandom_range(0, 4) != 0;
      r_s1 = $urandom_range(0, 4) != 0;
      r_e0 = $urandom_range(0, 5) != 0;
      r_e1 = 1'($urandom_range(0, 1));
      send_frame(r_d, r_m, r_pb, r_s0, r_s1, r_e0, r_e1, 1'b1);
      repeat (200) @(negedge clk);
      if (r_e0) model_push(ref_entry(r_d, r_m, r_pb, r_s0, r_s1));
      check_state($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d busy", i), 32'(busy), 0);
      pop();
      check_state($sformatf("rnd%0d pop", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
